// File: rtl/mdc_instream_tx_if.sv
// rtl/mdc_instream_tx_if.sv - upstream valid/ready and network data/wr/full bundle
interface mdc_instream_tx_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_wr;
    logic              tx_full;

    modport master (
        output in_data, in_valid, tx_full,
        input  in_ready, tx_data, tx_wr
    );

    modport slave (
        input  in_data, in_valid, tx_full,
        output in_ready, tx_data, tx_wr
    );
endinterface

// File: rtl/mdc_instream_tx.sv
// rtl/mdc_instream_tx.sv - framed stream transmitter into the network inStream port
module mdc_instream_tx #(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2,
    parameter int LEN_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] sent_cnt,
    mdc_instream_tx_if.slave bus
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [LEN_W-1:0]  sent_cnt_q, sent_cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [DATA_W-1:0] mem_d [BUF_DEPTH];
    logic              run;
    logic              push;
    logic              pop;

    // in_ready depends only on flops; tx_wr is the single combinational path (from tx_full)
    assign run          = (state_q == S_RUN);
    assign bus.in_ready = run && (fifo_cnt_q < DEPTH_C) && (acc_cnt_q < len_q);
    assign bus.tx_wr    = run && (fifo_cnt_q != '0) && !bus.tx_full;
    assign bus.tx_data  = mem_q[rd_ptr_q];
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.tx_wr;
    assign busy         = run;
    assign done         = (state_q == S_DONE);
    assign sent_cnt     = sent_cnt_q;

    // next-state: FIFO push/pop bookkeeping and job framing FSM
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_cnt_d  = acc_cnt_q;
        sent_cnt_d = sent_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        mem_d      = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            acc_cnt_d       = acc_cnt_q + LEN_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            sent_cnt_d = sent_cnt_q + LEN_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = len;
                    acc_cnt_d  = '0;
                    sent_cnt_d = '0;
                    state_d    = (len == '0) ? S_DONE : S_RUN;
                end
            end
            // every accepted word has left once sent_cnt equals len, so the FIFO is empty here
            S_RUN:   if (sent_cnt_q == len_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; reset aborts any job and flushes the FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            acc_cnt_q  <= '0;
            sent_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_cnt_q  <= acc_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            mem_q      <= mem_d;
        end
    end
endmodule
